// File: rtl/mem_channel_responder_pkg.sv
// gpu_mem_pkg: types and default sizes shared by the memory channel responder.
//   chan_state_e : per-channel request FSM state
//   op_e         : operation latched by a channel
//   DEF_*        : default geometry used by the interface, channel and top
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_BUSY = 2'd1,
    CH_RESP = 2'd2
  } chan_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_LATENCY      = 2;

endpackage

// File: rtl/mem_channel_responder_if.sv
// mem_channel_if: multi-channel read/write request bus between the memory
// arbiter (master) and the memory responder (slave).
//   mem_read_valid/address        : per-channel read request, channel c at [c*ADDR_BITS +: ADDR_BITS]
//   mem_read_ready/data           : one-cycle completion pulse with read data
//   mem_write_valid/address/data  : per-channel write request
//   mem_write_ready               : one-cycle write completion pulse
interface mem_channel_if
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
);

  logic [NUM_CHANNELS-1:0]           mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]           mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]           mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]           mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/mem_channel_responder_chan.sv
// mem_responder_chan: request FSM, latency counter and latched operands for
// one memory channel. Emits next-state strobes so the top can register the
// read word / commit the write on the same edge that enters RESP.
// Write ports exist only with MEM_RESPONDER_WRITE_EN defined.
//   clk, reset         : clock, synchronous active-high reset
//   rd_valid_i/addr_i  : read request from the arbiter
//   wr_valid_i/addr_i/data_i : write request (write build only)
//   rd_fire_o          : this edge enters RESP with a read
//   commit_o/commit_data_o : this edge enters RESP with a write (write build only)
//   addr_o             : address belonging to the strobes above
//
// state   | meaning
// CH_IDLE | waiting for a request; read wins over write
// CH_BUSY | latency counter running down
// CH_RESP | ready pulse is on the output this cycle
module mem_responder_chan
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
`ifdef MEM_RESPONDER_WRITE_EN
  parameter int DATA_BITS = DEF_DATA_BITS,
`endif
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_valid_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
`ifdef MEM_RESPONDER_WRITE_EN
  input  logic                 wr_valid_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  output logic                 commit_o,
  output logic [DATA_BITS-1:0] commit_data_o,
`endif
  output logic                 rd_fire_o,
  output logic [ADDR_BITS-1:0] addr_o
);

  localparam int CNT_BITS = $clog2(LATENCY + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  chan_state_e state_q, state_d;
  op_e op_q, op_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
`ifdef MEM_RESPONDER_WRITE_EN
  logic [DATA_BITS-1:0] data_q, data_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
`ifdef MEM_RESPONDER_WRITE_EN
    data_d  = data_q;
`endif
    case (state_q)
      CH_IDLE: begin
        if (rd_valid_i) begin
          op_d    = OP_READ;
          addr_d  = rd_addr_i;
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? CH_RESP : CH_BUSY;
        end
`ifdef MEM_RESPONDER_WRITE_EN
        else if (wr_valid_i) begin
          op_d    = OP_WRITE;
          addr_d  = wr_addr_i;
          data_d  = wr_data_i;
          cnt_d   = CNT_LOAD;
          state_d = (CNT_LOAD == '0) ? CH_RESP : CH_BUSY;
        end
`endif
      end
      CH_BUSY: begin
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_d == '0) state_d = CH_RESP;
      end
      CH_RESP: state_d = CH_IDLE;
      default: state_d = CH_IDLE;
    endcase
  end

  // Strobes look at the next state so the array access lines up with the
  // edge that raises ready; addr_d already holds the operand in that case.
  assign rd_fire_o = (state_d == CH_RESP) && (op_d == OP_READ);
  assign addr_o    = addr_d;
`ifdef MEM_RESPONDER_WRITE_EN
  assign commit_o      = (state_d == CH_RESP) && (op_d == OP_WRITE);
  assign commit_data_o = data_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      op_q    <= OP_READ;
      cnt_q   <= '0;
      addr_q  <= '0;
`ifdef MEM_RESPONDER_WRITE_EN
      data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
`ifdef MEM_RESPONDER_WRITE_EN
      data_q  <= data_d;
`endif
    end
  end

endmodule

// File: rtl/mem_channel_responder.sv
// mem_channel_responder: behavioural memory behind the multi-channel memory
// interface. One mem_responder_chan per channel shares a single array; the
// top registers ready pulses and read data and commits writes.
//   clk    : clock, rising edge
//   reset  : synchronous active-high; array contents are kept
//   bus    : mem_channel_if.slave (read/write request and response bus)
// Macro MEM_RESPONDER_WRITE_EN enables the write path. Without it the array
// is read-only program memory: write requests are ignored, mem_write_ready
// is 0, and the array is preloaded directly in simulation.
module mem_channel_responder
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int LATENCY      = DEF_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  mem_channel_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0]              mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0]           rd_fire;
  logic [ADDR_BITS-1:0]              chan_addr [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]           rd_ready_q;
  logic [NUM_CHANNELS*DATA_BITS-1:0] rd_data_q;
`ifdef MEM_RESPONDER_WRITE_EN
  logic [NUM_CHANNELS-1:0]           commit;
  logic [DATA_BITS-1:0]              commit_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]           wr_ready_q;
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    mem_responder_chan #(
      .ADDR_BITS (ADDR_BITS),
`ifdef MEM_RESPONDER_WRITE_EN
      .DATA_BITS (DATA_BITS),
`endif
      .LATENCY   (LATENCY)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .rd_valid_i    (bus.mem_read_valid[c]),
      .rd_addr_i     (bus.mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
`ifdef MEM_RESPONDER_WRITE_EN
      .wr_valid_i    (bus.mem_write_valid[c]),
      .wr_addr_i     (bus.mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
      .wr_data_i     (bus.mem_write_data[c*DATA_BITS +: DATA_BITS]),
      .commit_o      (commit[c]),
      .commit_data_o (commit_data[c]),
`endif
      .rd_fire_o     (rd_fire[c]),
      .addr_o        (chan_addr[c])
    );
  end

  // Reads sample the array with non-blocking semantics, so a read landing on
  // the same edge as a write to that address returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ready_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_ready_q <= rd_fire;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (rd_fire[c]) rd_data_q[c*DATA_BITS +: DATA_BITS] <= mem_q[chan_addr[c]];
      end
    end
  end

  assign bus.mem_read_ready = rd_ready_q;
  assign bus.mem_read_data  = rd_data_q;

`ifdef MEM_RESPONDER_WRITE_EN
  always_ff @(posedge clk) begin
    if (reset) wr_ready_q <= '0;
    else       wr_ready_q <= commit;
  end

  // Ascending loop: the highest channel index writing an address wins.
  // Reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (commit[c]) mem_q[chan_addr[c]] <= commit_data[c];
      end
    end
  end

  assign bus.mem_write_ready = wr_ready_q;
`else
  assign bus.mem_write_ready = '0;
`endif

endmodule
